lock_ctrl_fsm: RTL and testbench

Sequencing controller for the keypad lock. It consumes the scanner's debounced key_code/key_valid, collects a PIN and compares it against a stored PIN. It drives the unlock output, enforces a failed-attempt lockout and supports PIN change while unlocked. It sits between the keypad scanner and the board LEDs/actuator on the 125 MHz clock domain.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/lock_timer.sv | 39 +++
 rtl/lock_ctrl_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_lock_ctrl_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller: FSM state
// encoding, special key codes and the digit classifier.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_NEW_PIN  = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] KEY_CHG  = 4'hA;

  // Wide enough for 1.25e9 cycles at 125 MHz.
  localparam int TIMER_W = 31;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock, lockout and entry-timeout
// phases. It stops at zero and flags it.
module lock_timer
  import lock_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lock_ctrl_fsm.sv
// Keypad lock sequencer: collects PIN digits on key-press edges, checks them
// against the stored PIN, drives unlock/lockout and handles PIN change.
module lock_ctrl_fsm
  import lock_pkg::*;
#(
  parameter int                    PIN_LEN        = 4,
  parameter int                    MAX_FAILS      = 3,
  parameter logic [PIN_LEN*4-1:0]  DEFAULT_PIN    = 16'h1234,
  parameter int unsigned           UNLOCK_CYCLES  = 625000000,
  parameter int unsigned           LOCKOUT_CYCLES = 1250000000,
  parameter int unsigned           TIMEOUT_CYCLES = 1250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       unlocked,
  output logic       locked_out,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [3:0] digit_count,
  output logic [3:0] fail_count,
  output logic [2:0] state
);

  localparam int PW = PIN_LEN * 4;

  state_e        state_q, state_d;
  logic [PW-1:0] entry_buf_q, entry_buf_d;
  logic [PW-1:0] pin_q, pin_d;
  logic [3:0]    digit_count_q, digit_count_d;
  logic [3:0]    fail_count_q, fail_count_d;
  logic          ok_pulse_q, ok_pulse_d;
  logic          err_pulse_q, err_pulse_d;
  logic          unlocked_q, unlocked_d;
  logic          locked_out_q, locked_out_d;
  logic          key_valid_q, key_valid_d;
  logic          key_armed_q, key_armed_d;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_zero;

  logic          key_event;
  logic          key_digit;
  logic          count_full;
  logic          in_entry;
  logic [PW-1:0] buf_shift;
  logic [3:0]    fail_inc;

  // A key still held when reset releases must be let go before it can fire,
  // so edges are only accepted once key_valid has been seen low.
  assign key_event  = key_valid & ~key_valid_q & key_armed_q;
  assign key_digit  = key_event & is_digit(key_code);
  assign count_full = (digit_count_q == 4'(PIN_LEN));
  assign in_entry   = (state_q == S_ENTRY);
  assign buf_shift  = (entry_buf_q << 4) | PW'(key_code);
  assign fail_inc   = fail_count_q + 4'd1;

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    entry_buf_d   = entry_buf_q;
    pin_d         = pin_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    ok_pulse_d    = 1'b0;
    err_pulse_d   = 1'b0;
    key_valid_d   = key_valid;
    key_armed_d   = key_armed_q | ~key_valid;
    tmr_load      = 1'b0;
    tmr_val       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (key_digit) begin
          entry_buf_d   = PW'(key_code);
          digit_count_d = 4'd1;
          state_d       = S_ENTRY;
        end
      end

      S_ENTRY, S_NEW_PIN: begin
        if (key_digit) begin
          tmr_load = 1'b1;
          if (!count_full) begin
            entry_buf_d   = buf_shift;
            digit_count_d = digit_count_q + 4'd1;
          end
        end else if (key_event && key_code == KEY_STAR) begin
          entry_buf_d   = '0;
          digit_count_d = '0;
          state_d       = in_entry ? S_IDLE : S_UNLOCKED;
        end else if (key_event && key_code == KEY_HASH) begin
          if (in_entry) begin
            state_d = S_CHECK;
          end else begin
            if (count_full) begin
              pin_d      = entry_buf_q;
              ok_pulse_d = 1'b1;
            end else begin
              err_pulse_d = 1'b1;
            end
            entry_buf_d   = '0;
            digit_count_d = '0;
            state_d       = S_UNLOCKED;
          end
        end else if (tmr_zero) begin
          entry_buf_d   = '0;
          digit_count_d = '0;
          state_d       = in_entry ? S_IDLE : S_UNLOCKED;
        end
      end

      S_CHECK: begin
        entry_buf_d   = '0;
        digit_count_d = '0;
        if (count_full && entry_buf_q == pin_q) begin
          ok_pulse_d   = 1'b1;
          fail_count_d = '0;
          state_d      = S_UNLOCKED;
        end else begin
          err_pulse_d  = 1'b1;
          fail_count_d = fail_inc;
          state_d      = (fail_inc == 4'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
        end
      end

      S_UNLOCKED: begin
        if (key_event && key_code == KEY_HASH) begin
          state_d = S_IDLE;
        end else if (key_event && key_code == KEY_CHG) begin
          entry_buf_d   = '0;
          digit_count_d = '0;
          state_d       = S_NEW_PIN;
        end else if (tmr_zero) begin
          state_d = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (tmr_zero) begin
          fail_count_d = '0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Any state change restarts the timer with the duration of the new state.
    if (state_d != state_q) begin
      tmr_load = 1'b1;
    end
    unique case (state_d)
      S_UNLOCKED:         tmr_val = TIMER_W'(UNLOCK_CYCLES - 1);
      S_LOCKOUT:          tmr_val = TIMER_W'(LOCKOUT_CYCLES - 1);
      S_ENTRY, S_NEW_PIN: tmr_val = TIMER_W'(TIMEOUT_CYCLES - 1);
      default:            tmr_val = '0;
    endcase

    unlocked_d   = (state_d == S_UNLOCKED) || (state_d == S_NEW_PIN);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  // NOTE: the stored PIN is a handful of flops, not a memory, so it is reset
  // to DEFAULT_PIN like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      entry_buf_q   <= '0;
      pin_q         <= DEFAULT_PIN;
      digit_count_q <= '0;
      fail_count_q  <= '0;
      ok_pulse_q    <= 1'b0;
      err_pulse_q   <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
      key_valid_q   <= 1'b0;
      key_armed_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_buf_q   <= entry_buf_d;
      pin_q         <= pin_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      ok_pulse_q    <= ok_pulse_d;
      err_pulse_q   <= err_pulse_d;
      unlocked_q    <= unlocked_d;
      locked_out_q  <= locked_out_d;
      key_valid_q   <= key_valid_d;
      key_armed_q   <= key_armed_d;
    end
  end

  lock_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign unlocked    = unlocked_q;
  assign locked_out  = locked_out_q;
  assign ok_pulse    = ok_pulse_q;
  assign err_pulse   = err_pulse_q;
  assign digit_count = digit_count_q;
  assign fail_count  = fail_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Directed bench for lock_ctrl_fsm with short timer settings
// (unlock 50, lockout 100, timeout 200 cycles).
module tb_lock_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic       unlocked, locked_out, ok_pulse, err_pulse;
  logic [3:0] digit_count, fail_count;
  logic [2:0] state;

  int tot = 0;
  int bad = 0;

  // Pulse and level activity, sampled on the falling edge.
  int   ok_cnt = 0, err_cnt = 0, unl_cnt = 0, lock_cnt = 0, dbl_cnt = 0;
  logic ok_prev = 1'b0, err_prev = 1'b0;

  always #5 clk = ~clk;

  lock_ctrl_fsm #(
    .UNLOCK_CYCLES  (50),
    .LOCKOUT_CYCLES (100),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .ok_pulse    (ok_pulse),
    .err_pulse   (err_pulse),
    .digit_count (digit_count),
    .fail_count  (fail_count),
    .state       (state)
  );

  always @(negedge clk) begin
    if (ok_pulse)   ok_cnt++;
    if (err_pulse)  err_cnt++;
    if (unlocked)   unl_cnt++;
    if (locked_out) lock_cnt++;
    if ((ok_pulse && ok_prev) || (err_pulse && err_prev)) dbl_cnt++;
    ok_prev  = ok_pulse;
    err_prev = err_pulse;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    cycles(10);
    key_valid = 1'b0;
    cycles(10);
  endtask

  // Presses n keys given as hex nibbles, most significant first.
  task automatic enter_keys(input logic [31:0] keys, input int n);
    for (int i = n - 1; i >= 0; i--) press(keys[4*i +: 4]);
  endtask

  task automatic test_reset;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    cycles(3);
    tot++; if (state !== 3'd0)       begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    tot++; if (unlocked !== 1'b0)    begin bad++; $display("FAIL reset_unlocked got=%b want=0", unlocked); end
    tot++; if (locked_out !== 1'b0)  begin bad++; $display("FAIL reset_locked_out got=%b want=0", locked_out); end
    tot++; if (ok_pulse !== 1'b0 || err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", ok_pulse, err_pulse); end
    tot++; if (digit_count !== 4'd0 || fail_count !== 4'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", digit_count, fail_count); end
    rst = 1'b0;
    cycles(3);
  endtask

  task automatic test_unlock;
    int o0, u0, d0;
    o0 = ok_cnt; u0 = unl_cnt; d0 = dbl_cnt;
    enter_keys(32'h1234F, 5);
    tot++; if (unlocked !== 1'b1) begin bad++; $display("FAIL unlock_open got=%b want=1", unlocked); end
    tot++; if (state !== 3'd3)    begin bad++; $display("FAIL unlock_state got=%0d want=3", state); end
    cycles(60);
    tot++; if (ok_cnt - o0 !== 1)  begin bad++; $display("FAIL unlock_ok_count got=%0d want=1", ok_cnt - o0); end
    tot++; if (unl_cnt - u0 !== 50) begin bad++; $display("FAIL unlock_hold_cycles got=%0d want=50", unl_cnt - u0); end
    tot++; if (unlocked !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL unlock_relock got=%b/%0d want=0/0", unlocked, state); end
    tot++; if (dbl_cnt - d0 !== 0) begin bad++; $display("FAIL unlock_pulse_width got=%0d want=0", dbl_cnt - d0); end
  endtask

  task automatic test_lockout;
    int e0, o0, l0;
    l0 = lock_cnt;
    for (int a = 1; a <= 3; a++) begin
      e0 = err_cnt;
      enter_keys(32'h1235F, 5);
      tot++; if (err_cnt - e0 !== 1)    begin bad++; $display("FAIL lockout_err_%0d got=%0d want=1", a, err_cnt - e0); end
      tot++; if (fail_count !== 4'(a)) begin bad++; $display("FAIL lockout_fails_%0d got=%0d want=%0d", a, fail_count, a); end
    end
    tot++; if (locked_out !== 1'b1 || state !== 3'd5) begin bad++; $display("FAIL lockout_enter got=%b/%0d want=1/5", locked_out, state); end
    o0 = ok_cnt; e0 = err_cnt;
    enter_keys(32'h1F, 2);
    tot++; if (state !== 3'd5 || digit_count !== 4'd0) begin bad++; $display("FAIL lockout_keys_ignored got=%0d/%0d want=5/0", state, digit_count); end
    tot++; if ((ok_cnt - o0) + (err_cnt - e0) !== 0) begin bad++; $display("FAIL lockout_no_pulse got=%0d want=0", (ok_cnt - o0) + (err_cnt - e0)); end
    cycles(60);
    tot++; if (locked_out !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL lockout_exit got=%b/%0d want=0/0", locked_out, state); end
    tot++; if (fail_count !== 4'd0) begin bad++; $display("FAIL lockout_fail_clear got=%0d want=0", fail_count); end
    tot++; if (lock_cnt - l0 !== 100) begin bad++; $display("FAIL lockout_duration got=%0d want=100", lock_cnt - l0); end
  endtask

  task automatic test_short_and_extra;
    int e0, o0;
    e0 = err_cnt;
    enter_keys(32'h12F, 3);
    tot++; if (err_cnt - e0 !== 1 || fail_count !== 4'd1) begin bad++; $display("FAIL short_entry got=%0d/%0d want=1/1", err_cnt - e0, fail_count); end
    enter_keys(32'h12345, 5);
    tot++; if (digit_count !== 4'd4 || state !== 3'd1) begin bad++; $display("FAIL extra_digit_sat got=%0d/%0d want=4/1", digit_count, state); end
    o0 = ok_cnt;
    press(4'hF);
    tot++; if (ok_cnt - o0 !== 1 || unlocked !== 1'b1) begin bad++; $display("FAIL extra_digit_unlock got=%0d/%b want=1/1", ok_cnt - o0, unlocked); end
    tot++; if (fail_count !== 4'd0) begin bad++; $display("FAIL extra_fail_clear got=%0d want=0", fail_count); end
    cycles(60);
  endtask

  task automatic test_pin_change;
    int e0, o0;
    enter_keys(32'h1234F, 5);
    press(4'hA);
    tot++; if (state !== 3'd4 || unlocked !== 1'b1) begin bad++; $display("FAIL chg_enter got=%0d/%b want=4/1", state, unlocked); end
    o0 = ok_cnt;
    enter_keys(32'h9876F, 5);
    tot++; if (ok_cnt - o0 !== 1 || state !== 3'd3) begin bad++; $display("FAIL chg_accept got=%0d/%0d want=1/3", ok_cnt - o0, state); end
    e0 = err_cnt;
    enter_keys(32'hA1F, 3);
    tot++; if (err_cnt - e0 !== 1 || state !== 3'd3 || fail_count !== 4'd0) begin bad++; $display("FAIL chg_short got=%0d/%0d/%0d want=1/3/0", err_cnt - e0, state, fail_count); end
    cycles(60);
    tot++; if (state !== 3'd0) begin bad++; $display("FAIL chg_relock got=%0d want=0", state); end
    e0 = err_cnt;
    enter_keys(32'h1234F, 5);
    tot++; if (err_cnt - e0 !== 1 || fail_count !== 4'd1) begin bad++; $display("FAIL chg_old_pin got=%0d/%0d want=1/1", err_cnt - e0, fail_count); end
    o0 = ok_cnt;
    enter_keys(32'h9876F, 5);
    tot++; if (ok_cnt - o0 !== 1 || unlocked !== 1'b1) begin bad++; $display("FAIL chg_new_pin got=%0d/%b want=1/1", ok_cnt - o0, unlocked); end
    cycles(60);
  endtask

  task automatic test_timeout;
    enter_keys(32'h1F, 2);
    enter_keys(32'h12, 2);
    tot++; if (state !== 3'd1 || digit_count !== 4'd2) begin bad++; $display("FAIL timeout_pre got=%0d/%0d want=1/2", state, digit_count); end
    cycles(200);
    tot++; if (state !== 3'd0 || digit_count !== 4'd0) begin bad++; $display("FAIL timeout_clear got=%0d/%0d want=0/0", state, digit_count); end
    tot++; if (fail_count !== 4'd1) begin bad++; $display("FAIL timeout_fails got=%0d want=1", fail_count); end
    key_code = 4'h7; key_valid = 1'b1;
    cycles(150);
    tot++; if (digit_count !== 4'd1 || state !== 3'd1) begin bad++; $display("FAIL hold_one_event got=%0d/%0d want=1/1", digit_count, state); end
    cycles(350);
    tot++; if (digit_count !== 4'd0 || state !== 3'd0) begin bad++; $display("FAIL hold_no_repeat got=%0d/%0d want=0/0", digit_count, state); end
    key_valid = 1'b0;
    cycles(10);
  endtask

  task automatic test_reset_mid;
    int e0, o0;
    enter_keys(32'h12, 2);
    key_code = 4'h3; key_valid = 1'b1;
    cycles(2);
    tot++; if (digit_count !== 4'd3) begin bad++; $display("FAIL mid_pre got=%0d want=3", digit_count); end
    rst = 1'b1;
    #2;
    tot++; if (state !== 3'd0 || digit_count !== 4'd0 || fail_count !== 4'd0) begin bad++; $display("FAIL mid_reset got=%0d/%0d/%0d want=0/0/0", state, digit_count, fail_count); end
    tot++; if (unlocked !== 1'b0 || locked_out !== 1'b0 || ok_pulse !== 1'b0 || err_pulse !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%b%b%b%b want=0000", unlocked, locked_out, ok_pulse, err_pulse); end
    cycles(3);
    rst = 1'b0;
    cycles(5);
    tot++; if (state !== 3'd0 || digit_count !== 4'd0) begin bad++; $display("FAIL held_across_reset got=%0d/%0d want=0/0", state, digit_count); end
    key_valid = 1'b0;
    cycles(10);
    o0 = ok_cnt;
    enter_keys(32'h1234F, 5);
    press(4'hA);
    enter_keys(32'h5555F, 5);
    tot++; if (ok_cnt - o0 !== 2) begin bad++; $display("FAIL rst_chg_setup got=%0d want=2", ok_cnt - o0); end
    rst = 1'b1;
    #2;
    tot++; if (state !== 3'd0 || unlocked !== 1'b0) begin bad++; $display("FAIL rst_after_chg got=%0d/%b want=0/0", state, unlocked); end
    cycles(2);
    rst = 1'b0;
    cycles(3);
    e0 = err_cnt;
    enter_keys(32'h5555F, 5);
    tot++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL rst_changed_pin_gone got=%0d want=1", err_cnt - e0); end
    o0 = ok_cnt;
    enter_keys(32'h1234F, 5);
    tot++; if (ok_cnt - o0 !== 1 || unlocked !== 1'b1) begin bad++; $display("FAIL rst_default_pin got=%0d/%b want=1/1", ok_cnt - o0, unlocked); end
    cycles(60);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    test_reset;
    test_unlock;
    test_lockout;
    test_short_and_extra;
    test_pin_change;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
